// File: rtl/control_unit_if.sv
// Control bundle between the multicycle control unit (master) and the 16-bit CPU datapath (slave).
// The datapath side owns ir, flags and ram_ready. The control unit drives every strobe and select.
interface control_unit_if #(
  parameter int FLAG_W  = 4,
  parameter int ALUOP_W = 3
);
  logic [15:0]        ir;
  logic [FLAG_W-1:0]  flags;
  logic               ram_ready;

  logic               pc_we;
  logic               ir_we;
  logic               mar_we;
  logic               mdr_we;
  logic               acc_we;
  logic               a_we;
  logic               b_we;
  logic               flags_we;
  logic               rf_we;
  logic               ram_req;
  logic               ram_we;
  logic [1:0]         adder_sel;
  logic               reg2_sel;
  logic [1:0]         dataw_sel;
  logic               alu_b_sel;
  logic [ALUOP_W-1:0] alu_op;
  logic               halted;
  logic               illegal;

  modport master (
    input  ir, flags, ram_ready,
    output pc_we, ir_we, mar_we, mdr_we, acc_we, a_we, b_we, flags_we,
           rf_we, ram_req, ram_we, adder_sel, reg2_sel, dataw_sel,
           alu_b_sel, alu_op, halted, illegal
  );

  modport slave (
    output ir, flags, ram_ready,
    input  pc_we, ir_we, mar_we, mdr_we, acc_we, a_we, b_we, flags_we,
           rf_we, ram_req, ram_we, adder_sel, reg2_sel, dataw_sel,
           alu_b_sel, alu_op, halted, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle FSM sequencing the 16-bit CPU datapath.
// Strobes are registered from the next state, so each one lines up with the state it belongs to.
module control_unit #(
  parameter int OPC_W   = 4,
  parameter int ALUOP_W = 3,
  parameter int FLAG_W  = 4
) (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.master io_bus
);

  localparam int Z_BIT = 2;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_XOR  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(15);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB_ALU, S_WB_IMM, S_ADDR,
    S_MEM, S_WB_MEM, S_BRANCH, S_HALT, S_ILLEGAL
  } state_t;

  typedef struct packed {
    logic               pc_we;
    logic               ir_we;
    logic               mar_we;
    logic               acc_we;
    logic               a_we;
    logic               b_we;
    logic               flags_we;
    logic               rf_we;
    logic               ram_req;
    logic               ram_we;
    logic [1:0]         adder_sel;
    logic               reg2_sel;
    logic [1:0]         dataw_sel;
    logic               alu_b_sel;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  state_t           r_state;
  state_t           w_next;
  ctrl_t            r_ctrl;
  logic             r_halted;
  logic             r_illegal;
  logic [OPC_W-1:0] w_opc;
  logic             w_z;
  logic             w_unused;

  assign w_opc    = io_bus.ir[15 -: OPC_W];
  assign w_z      = io_bus.flags[Z_BIT];
  // Operand fields are consumed by the datapath. Only the opcode and Z matter here.
  assign w_unused = ^{io_bus.ir[15-OPC_W:0], io_bus.flags[FLAG_W-1:0]};

  function automatic ctrl_t f_ctrl(input state_t s, input logic [OPC_W-1:0] opc, input logic z);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_we = 1'b1;
        c.pc_we = 1'b1;
      end
      S_DECODE: begin
        c.a_we = 1'b1;
        c.b_we = 1'b1;
      end
      S_EXEC: begin
        c.acc_we   = 1'b1;
        c.flags_we = 1'b1;
        case (opc)
          OP_SUB:  c.alu_op = ALUOP_W'(1);
          OP_AND:  c.alu_op = ALUOP_W'(2);
          OP_OR:   c.alu_op = ALUOP_W'(3);
          OP_XOR:  c.alu_op = ALUOP_W'(4);
          default: c.alu_op = ALUOP_W'(0);
        endcase
        c.alu_b_sel = (opc == OP_ADDI);
      end
      S_WB_ALU: c.rf_we = 1'b1;
      S_WB_IMM: begin
        c.rf_we     = 1'b1;
        c.dataw_sel = 2'd2;
      end
      // Address = base register + se4 offset. Stores also fetch their data register into reg_b.
      S_ADDR: begin
        c.alu_b_sel = 1'b1;
        c.mar_we    = 1'b1;
        c.b_we      = 1'b1;
        c.reg2_sel  = (opc == OP_ST);
      end
      S_MEM: begin
        c.ram_req  = 1'b1;
        c.ram_we   = (opc == OP_ST);
        c.reg2_sel = (opc == OP_ST);
      end
      S_WB_MEM: begin
        c.rf_we     = 1'b1;
        c.dataw_sel = 2'd1;
      end
      S_BRANCH: begin
        if (opc == OP_JMP) begin
          c.pc_we     = 1'b1;
          c.adder_sel = 2'd2;
        end else begin
          c.pc_we     = (opc == OP_BEQ) ? z : ~z;
          c.adder_sel = 2'd1;
        end
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_opc)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: w_next = S_EXEC;
          OP_LDI:                 w_next = S_WB_IMM;
          OP_LD, OP_ST:           w_next = S_ADDR;
          OP_JMP, OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_NOP:                 w_next = S_FETCH;
          OP_HALT:                w_next = S_HALT;
          default:                w_next = S_ILLEGAL;
        endcase
      end
      S_EXEC:   w_next = S_WB_ALU;
      S_ADDR:   w_next = S_MEM;
      S_MEM: begin
        if (!io_bus.ram_ready)   w_next = S_MEM;
        else if (w_opc == OP_LD) w_next = S_WB_MEM;
        else                     w_next = S_FETCH;
      end
      S_HALT:    w_next = S_HALT;
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_FETCH;
    endcase
  end

  // Reset preloads the FETCH strobes so the first cycle after release already fetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_ctrl    <= f_ctrl(S_FETCH, w_opc, w_z);
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_ctrl    <= f_ctrl(w_next, w_opc, w_z);
      r_halted  <= r_halted  | (w_next == S_HALT);
      r_illegal <= r_illegal | (w_next == S_ILLEGAL);
    end
  end

  // The preloaded fetch strobes stay masked while reset is held.
  assign io_bus.pc_we     = r_ctrl.pc_we & ~rst;
  assign io_bus.ir_we     = r_ctrl.ir_we & ~rst;
  assign io_bus.mar_we    = r_ctrl.mar_we;
  assign io_bus.acc_we    = r_ctrl.acc_we;
  assign io_bus.a_we      = r_ctrl.a_we;
  assign io_bus.b_we      = r_ctrl.b_we;
  assign io_bus.flags_we  = r_ctrl.flags_we;
  assign io_bus.rf_we     = r_ctrl.rf_we;
  assign io_bus.ram_req   = r_ctrl.ram_req;
  assign io_bus.ram_we    = r_ctrl.ram_we;
  assign io_bus.adder_sel = r_ctrl.adder_sel;
  assign io_bus.reg2_sel  = r_ctrl.reg2_sel;
  assign io_bus.dataw_sel = r_ctrl.dataw_sel;
  assign io_bus.alu_b_sel = r_ctrl.alu_b_sel;
  assign io_bus.alu_op    = r_ctrl.alu_op;
  assign io_bus.halted    = r_halted;
  assign io_bus.illegal   = r_illegal;

  // Load data must be captured in the cycle memory completes. A completion during reset is dropped.
  assign io_bus.mdr_we = (r_state == S_MEM) & (w_opc == OP_LD) & io_bus.ram_ready & ~rst;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: builds the expected per-cycle strobe trace of each
// instruction from its opcode class, then compares it against the DUT one cycle at a time.
module tb_control_unit;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  control_unit_if bus ();

  control_unit dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct packed {
    logic       pc;
    logic       ir;
    logic       mar;
    logic       mdr;
    logic       acc;
    logic       a;
    logic       b;
    logic       flg;
    logic       rf;
    logic       req;
    logic       rwe;
    logic [1:0] adder;
    logic       reg2;
    logic [1:0] dataw;
    logic       aluB;
    logic [2:0] aluOp;
    logic       halted;
    logic       illegal;
  } vec_t;

  vec_t expQ[$];
  logic readyQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic vec_t observe();
    vec_t v;
    v.pc      = bus.pc_we;
    v.ir      = bus.ir_we;
    v.mar     = bus.mar_we;
    v.mdr     = bus.mdr_we;
    v.acc     = bus.acc_we;
    v.a       = bus.a_we;
    v.b       = bus.b_we;
    v.flg     = bus.flags_we;
    v.rf      = bus.rf_we;
    v.req     = bus.ram_req;
    v.rwe     = bus.ram_we;
    v.adder   = bus.adder_sel;
    v.reg2    = bus.reg2_sel;
    v.dataw   = bus.dataw_sel;
    v.aluB    = bus.alu_b_sel;
    v.aluOp   = bus.alu_op;
    v.halted  = bus.halted;
    v.illegal = bus.illegal;
    return v;
  endfunction

  function automatic void pushCycle(input vec_t v, input logic ready);
    expQ.push_back(v);
    readyQ.push_back(ready);
  endfunction

  // Reference trace per instruction class; ram_ready is random wherever memory is not being waited on.
  function automatic void buildExpected(input logic [15:0] instr, input logic z, input int waitCycles);
    vec_t v;
    logic [3:0] op;
    logic isSt;
    op   = instr[15:12];
    isSt = (op == 4'h9);
    expQ.delete();
    readyQ.delete();
    v = '0; v.pc = 1'b1; v.ir = 1'b1;
    pushCycle(v, 1'($urandom_range(0, 1)));
    v = '0; v.a = 1'b1; v.b = 1'b1;
    pushCycle(v, 1'($urandom_range(0, 1)));
    if (op >= 4'h1 && op <= 4'h6) begin
      v = '0; v.acc = 1'b1; v.flg = 1'b1;
      v.aluOp = (op == 4'h6) ? 3'd0 : 3'(op - 4'd1);
      v.aluB  = (op == 4'h6);
      pushCycle(v, 1'($urandom_range(0, 1)));
      v = '0; v.rf = 1'b1;
      pushCycle(v, 1'($urandom_range(0, 1)));
    end else if (op == 4'h7) begin
      v = '0; v.rf = 1'b1; v.dataw = 2'd2;
      pushCycle(v, 1'($urandom_range(0, 1)));
    end else if (op == 4'h8 || op == 4'h9) begin
      v = '0; v.aluB = 1'b1; v.mar = 1'b1; v.b = 1'b1; v.reg2 = isSt;
      pushCycle(v, 1'($urandom_range(0, 1)));
      v = '0; v.req = 1'b1; v.rwe = isSt; v.reg2 = isSt;
      for (int w = 0; w < waitCycles; w++) pushCycle(v, 1'b0);
      v.mdr = ~isSt;
      pushCycle(v, 1'b1);
      if (!isSt) begin
        v = '0; v.rf = 1'b1; v.dataw = 2'd1;
        pushCycle(v, 1'($urandom_range(0, 1)));
      end
    end else if (op >= 4'hA && op <= 4'hC) begin
      v = '0;
      v.adder = (op == 4'hA) ? 2'd2 : 2'd1;
      v.pc    = (op == 4'hA) ? 1'b1 : ((op == 4'hB) ? z : ~z);
      pushCycle(v, 1'($urandom_range(0, 1)));
    end else if (op >= 4'hD) begin
      v = '0;
      if (op == 4'hF) v.halted = 1'b1;
      else            v.illegal = 1'b1;
      for (int k = 0; k < 20; k++) pushCycle(v, 1'($urandom_range(0, 1)));
    end
  endfunction

  // Entered and left just after a rising edge; holds rst for two edges.
  task automatic doReset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset", 32'(observe()), 32'(vec_t'('0)));
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle; abortAt (1-based) raises rst in that cycle.
  task automatic applyStimulus(input logic [15:0] instr, input logic [3:0] flg,
                               input int waitCycles, input int abortAt, input string name);
    buildExpected(instr, flg[2], waitCycles);
    bus.ir    = instr;
    bus.flags = flg;
    for (int i = 0; i < expQ.size(); i++) begin
      bus.ram_ready = readyQ[i];
      if (i + 1 == abortAt) begin
        rst           = 1'b1;
        bus.ram_ready = 1'b1;
      end
      @(negedge clk);
      checkOutput($sformatf("%s %h c%0d", name, instr, i + 1), 32'(observe()), 32'(expQ[i]));
      @(posedge clk); #1;
      if (rst) begin
        rst = 1'b0;
        break;
      end
    end
    if (instr[15:12] >= 4'hD && abortAt == 0) doReset();
  endtask

  initial begin
    rst           = 1'b1;
    bus.ir        = 16'h0000;
    bus.flags     = 4'h0;
    bus.ram_ready = 1'b0;
    doReset();

    applyStimulus(16'h1123, 4'h0, 0, 0, "ADD");
    applyStimulus(16'h8120, 4'h0, 3, 0, "LD");
    applyStimulus(16'h9340, 4'h0, 0, 0, "ST");
    applyStimulus(16'hB0FE, 4'h4, 0, 0, "BEQ_Z1");
    applyStimulus(16'hB0FE, 4'hB, 0, 0, "BEQ_Z0");
    applyStimulus(16'hC0FE, 4'h4, 0, 0, "BNE_Z1");
    applyStimulus(16'hC0FE, 4'hB, 0, 0, "BNE_Z0");
    applyStimulus(16'hA123, 4'h0, 0, 0, "JMP");
    applyStimulus(16'h7155, 4'h0, 0, 0, "LDI");
    applyStimulus(16'h0FFF, 4'h0, 0, 0, "NOP");
    applyStimulus(16'h6127, 4'h0, 0, 0, "ADDI");
    applyStimulus(16'h2123, 4'h0, 0, 0, "SUB");
    applyStimulus(16'h3123, 4'h0, 0, 0, "AND");
    applyStimulus(16'h4123, 4'h0, 0, 0, "OR");
    applyStimulus(16'h5123, 4'h0, 0, 0, "XOR");
    applyStimulus(16'h9341, 4'h0, 2, 0, "ST_WAIT");
    applyStimulus(16'hF000, 4'h0, 0, 0, "HALT");
    applyStimulus(16'hD000, 4'h0, 0, 0, "ILL_D");
    applyStimulus(16'hE000, 4'h0, 0, 0, "ILL_E");
    applyStimulus(16'h8120, 4'h0, 3, 5, "LD_ABORT");
    applyStimulus(16'h1123, 4'h0, 0, 0, "ADD_AFTER");

    for (int n = 0; n < 80; n++) begin
      applyStimulus(16'($urandom), 4'($urandom), $urandom_range(0, 4), 0, "RND");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
